// File: rtl/pipeline_stage_elastic.sv
// pipeline_stage_elastic
// Elastic inter-stage pipeline register for the five-stage CPU. Carries a
// packed payload with a valid/ready handshake and a two-entry skid buffer, so
// full throughput is kept under backpressure while in_ready stays registered.
// Also provides a synchronous flush (branch squash) and saturating counters.
//
// state | meaning
// EMPTY | no entry held; main/skid hold stale or RESET_VAL data
// ONE   | main holds the head entry (out_valid=1), skid unused
// FULL  | main holds the head, skid holds the next entry (in_ready=0)
//
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   flush             synchronous squash of every held entry
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   occupancy         entries held (0..2)
//   stall_cycles      saturating count of out_valid & !out_ready & !flush
//   flush_drops       saturating count of valid entries discarded by flush
module pipeline_stage_elastic #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_drops
);

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    drops_q, drops_d;
  logic [CNT_W:0]      drop_sum;
  logic                take;

  assign in_ready     = (state_q != FULL);
  assign out_valid    = (state_q != EMPTY);
  assign occupancy    = state_q;
  assign out_data     = main_q;
  assign stall_cycles = stall_q;
  assign flush_drops  = drops_q;
  assign take         = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
      drops_q <= drops_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    stall_d  = stall_q;
    drops_d  = drops_q;
    // At most 2 is added, so the carry bit alone flags saturation.
    drop_sum = {1'b0, drops_q} + {{(CNT_W-1){1'b0}}, occupancy};

    if (flush) begin
      // Squash wins over any transfer or handshake-out in the same cycle.
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
      drops_d = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
    end else begin
      if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end

      case (state_q)
        EMPTY: begin
          if (take) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (take && out_ready) begin
            main_d = in_data;
          end else if (take) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
module tb_pipeline_stage_elastic;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_drops;

  int tests = 0;
  int fails = 0;

  pipeline_stage_elastic #(
    .DATA_W   (DW),
    .CNT_W    (CW),
    .RESET_VAL('0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .stall_cycles(stall_cycles),
    .flush_drops (flush_drops)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          ov;
    logic          ir;
    logic [DW-1:0] od;
    logic [1:0]    occ;
    logic [CW-1:0] st;
    logic [CW-1:0] dr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] id, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Random-run reference model: queue of accepted payloads in order.
  logic [DW-1:0] q [$];
  int            stall_m;
  int            drops_m;
  logic          last_flush;
  logic          r_fl, r_iv, r_or;
  logic [DW-1:0] r_id;

  initial begin
    //          fl iv id           or   ov ir od           occ st dr
    vecs[0]  = '{0, 1, 32'h1,       1,   1, 1, 32'h1,       1, 0, 0};
    vecs[1]  = '{0, 1, 32'h2,       1,   1, 1, 32'h2,       1, 0, 0};
    vecs[2]  = '{0, 1, 32'h3,       1,   1, 1, 32'h3,       1, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,       1,   0, 1, 32'h3,       0, 0, 0};
    vecs[4]  = '{0, 1, 32'hA,       0,   1, 1, 32'hA,       1, 0, 0};
    vecs[5]  = '{0, 1, 32'hB,       0,   1, 0, 32'hA,       2, 1, 0};
    vecs[6]  = '{0, 1, 32'hD,       0,   1, 0, 32'hA,       2, 2, 0};
    vecs[7]  = '{0, 0, 32'h0,       1,   1, 1, 32'hB,       1, 2, 0};
    vecs[8]  = '{0, 0, 32'h0,       1,   0, 1, 32'hB,       0, 2, 0};
    vecs[9]  = '{0, 1, 32'hA,       0,   1, 1, 32'hA,       1, 2, 0};
    vecs[10] = '{0, 1, 32'hB,       0,   1, 0, 32'hA,       2, 3, 0};
    vecs[11] = '{1, 1, 32'hC,       0,   0, 1, 32'h0,       0, 3, 2};
    vecs[12] = '{0, 0, 32'h0,       0,   0, 1, 32'h0,       0, 3, 2};
    vecs[13] = '{0, 1, 32'h5,       1,   1, 1, 32'h5,       1, 3, 2};
    vecs[14] = '{1, 1, 32'h6,       1,   0, 1, 32'h0,       0, 3, 3};
    vecs[15] = '{1, 1, 32'h7,       1,   0, 1, 32'h0,       0, 3, 3};
    vecs[16] = '{0, 1, 32'h8,       1,   1, 1, 32'h8,       1, 3, 3};
    vecs[17] = '{0, 1, 32'h9,       0,   1, 0, 32'h8,       2, 4, 3};
    vecs[18] = '{0, 1, 32'hE,       1,   1, 1, 32'h9,       1, 4, 3};
    vecs[19] = '{0, 1, 32'hF,       1,   1, 1, 32'hF,       1, 4, 3};
    vecs[20] = '{0, 0, 32'hDEAD,    1,   0, 1, 32'hF,       0, 4, 3};

    reset = 1'b1;
    drive(0, 0, '0, 0);
    #3;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst occupancy", 64'(occupancy), 64'(0));
    chk("rst out_data", 64'(out_data), 64'(0));
    chk("rst stall", 64'(stall_cycles), 64'(0));
    chk("rst drops", 64'(flush_drops), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
      chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].od));
      chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
      chk($sformatf("vec%0d stall", i), 64'(stall_cycles), 64'(vecs[i].st));
      chk($sformatf("vec%0d drops", i), 64'(flush_drops), 64'(vecs[i].dr));
    end

    // Asynchronous reset while FULL, between clock edges.
    drive(0, 1, 32'h11, 0);
    step();
    drive(0, 1, 32'h22, 0);
    step();
    drive(0, 0, '0, 0);
    chk("pre-async occupancy", 64'(occupancy), 64'(2));
    #3;
    reset = 1'b1;
    #1;
    chk("async out_valid", 64'(out_valid), 64'(0));
    chk("async in_ready", 64'(in_ready), 64'(1));
    chk("async occupancy", 64'(occupancy), 64'(0));
    chk("async out_data", 64'(out_data), 64'(0));
    chk("async stall", 64'(stall_cycles), 64'(0));
    chk("async drops", 64'(flush_drops), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    step();

    // stall_cycles saturates at 15 and does not wrap.
    drive(0, 1, 32'h33, 0);
    step();
    drive(0, 0, '0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("stall sat k=%0d", k), 64'(stall_cycles), 64'((k > 15) ? 15 : k));
    end
    chk("stall sat out_data", 64'(out_data), 64'(32'h33));
    chk("stall sat occupancy", 64'(occupancy), 64'(1));

    // flush_drops saturates at 15 when adding 2 to 14.
    pulse_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1, DW'(k), 0);
      step();
      drive(0, 1, DW'(k + 100), 0);
      step();
      drive(1, 0, '0, 0);
      step();
      drive(0, 0, '0, 0);
      chk($sformatf("drops sat k=%0d", k), 64'(flush_drops), 64'((2 * k > 15) ? 15 : 2 * k));
      chk($sformatf("drops sat occ k=%0d", k), 64'(occupancy), 64'(0));
    end

    // Random valid/ready/flush against an ordered-queue model.
    pulse_reset();
    q.delete();
    stall_m    = 0;
    drops_m    = 0;
    last_flush = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd occupancy", 64'(occupancy), 64'(q.size()));
      chk("rnd out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rnd in_ready", 64'(in_ready), 64'(q.size() != 2));
      chk("rnd stall", 64'(stall_cycles), 64'(stall_m));
      chk("rnd drops", 64'(flush_drops), 64'(drops_m));
      if (q.size() != 0) chk("rnd out_data", 64'(out_data), 64'(q[0]));
      else if (last_flush) chk("rnd flushed out_data", 64'(out_data), 64'(0));

      r_fl = ($urandom_range(0, 19) == 0);
      r_iv = ($urandom_range(0, 2) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_id = $urandom;
      drive(r_fl, r_iv, r_id, r_or);

      if (r_fl) begin
        drops_m    = (drops_m + q.size() > 15) ? 15 : drops_m + q.size();
        q.delete();
        last_flush = 1'b1;
      end else begin
        logic acc;
        acc = r_iv && (q.size() < 2);
        if (q.size() != 0 && !r_or && stall_m < 15) stall_m++;
        if (q.size() != 0 && r_or) begin
          void'(q.pop_front());
          last_flush = 1'b0;
        end
        if (acc) q.push_back(r_id);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_elastic.md
Name: pipeline_stage_elastic

Overview:
Generic, parametrised inter-stage pipeline register for the five-stage CPU. It replaces the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches with one elastic stage. The stage carries a packed payload bus with a valid/ready handshake and a two-entry skid buffer. It adds synchronous flush (branch squash), full-throughput backpressure (stall) and saturating performance counters. One instance sits between each pair of stages; the stage wrappers pack and unpack the instruction fields into the payload.

Parameters:
DATA_W, 32, payload width in bits (e.g. 32 for Inst only, 201 for the full EX/MEM bundle)
CNT_W, 16, width of each performance counter
RESET_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset and on flush

Ports:
clock  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
flush  input  1  synchronous squash of all held entries (branch taken / exception)
in_valid  input  1  upstream stage presents a payload
in_ready  output  1  this stage can accept a payload this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream stage consumes out_data this cycle
out_data  output  DATA_W  payload to downstream stage
occupancy  output  2  number of valid entries held (0..2)
stall_cycles  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_drops  output  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Storage: main register (drives out_data) and skid register; the state encodes their valid bits.
- A transfer occurs when in_valid=1 and in_ready=1; a handshake-out occurs when out_valid=1 and out_ready=1.
- in_ready = (state != FULL). It is registered-state derived and never depends combinationally on out_ready or in_valid.
- out_valid = (state != EMPTY); occupancy is EMPTY=0, ONE=1, FULL=2.
- States and transitions, when flush=0:
  - EMPTY: on transfer, main<=in_data and go to ONE; otherwise stay EMPTY.
  - ONE, transfer with out_ready=1: main<=in_data, stay ONE (pass-through, 1 payload/cycle).
  - ONE, transfer with out_ready=0: skid<=in_data, go to FULL.
  - ONE, no transfer with out_ready=1: go to EMPTY.
  - ONE, no transfer with out_ready=0: hold.
  - FULL, out_ready=1: main<=skid, go to ONE (in_ready is 0, so no input is taken).
  - FULL, out_ready=0: hold.
- Latency: 1 cycle from transfer to out_valid when the stage is empty. With continuous out_ready=1, throughput is 1 payload/cycle.
- Ordering: payloads exit strictly in acceptance order; none is lost or duplicated.
- Flush (synchronous, highest priority after reset):
  - Next state is EMPTY, and main and skid are both loaded with RESET_VAL.
  - Any transfer in the same cycle is discarded, and so is any handshake-out (the downstream must ignore it).
  - flush_drops += occupancy, saturating at 2^CNT_W-1.
- Reset (asynchronous, any time, including mid-FULL):
  - State EMPTY; main = skid = RESET_VAL, so out_data = RESET_VAL.
  - out_valid=0, in_ready=1, occupancy=0, stall_cycles=0, flush_drops=0.
  - Every output has a defined reset value; no field is left unreset.
- stall_cycles increments on each cycle with out_valid=1, out_ready=0 and flush=0. It saturates at 2^CNT_W-1 with no wrap, and flush does not clear it.
- out_data is stable while out_valid=1 and out_ready=0.
- When out_valid=0, out_data holds its last value (RESET_VAL after reset or flush).
- in_data is sampled only on a transfer; X on in_data while in_valid=0 must not propagate.

Test Plan:
- Reset then stream: reset, then in_valid=1 with in_data=0x1,0x2,0x3 on consecutive cycles and out_ready=1 -> out_data shows 0x1,0x2,0x3 one cycle after each input; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0 while 0xA and 0xB are sent -> occupancy 1 then 2, in_ready=0 after 0xB. Then raise out_ready=1 -> out_data shows 0xA, then 0xB; stall_cycles equals the number of held cycles (e.g. 3).
- Flush while FULL: hold 0xA,0xB, then flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, occupancy=0, out_data=0, flush_drops=2; 0xC never appears.
- Asynchronous reset mid-operation: assert reset between clock edges while FULL -> out_valid and occupancy drop immediately, out_data=RESET_VAL, both counters read 0.
- Counter saturation (CNT_W=4): hold out_ready=0 with one entry for 20 cycles -> stall_cycles stops at 15 and does not wrap.
- Random valid/ready (DATA_W=201): 10k cycles of random in_valid, out_ready and flush against a scoreboard -> in-order delivery, no loss or duplication except entries counted in flush_drops, and out_data stable under stall.
